// File: rtl/adc_pwm_table_reader.sv
// Avalon-MM read master that streams a word table from on-chip memory into a
// valid/ready stream, prefetching into a credit-controlled FIFO with optional looping.
module adc_pwm_table_reader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              loop_q, loop_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     used;
  logic              active;
  logic              flush;
  logic              push;
  logic              pop;
  logic              credit;

  assign out_valid      = (cnt_q != '0);
  assign out_data       = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign avm_read       = rd_q;
  assign avm_chipselect = rd_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;

  // In-flight covers the registered request plus the latency pipe; a pop this
  // cycle frees its slot early so the stream keeps one word per cycle.
  always_comb begin
    in_flight = CW'(rd_q);
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe_q[i]);
    end
    active = (state_q == S_RUN) || (state_q == S_DRAIN);
    flush  = active && stop;
    push   = pipe_q[READ_LATENCY-1] && active && !stop;
    pop    = out_valid && out_ready;
    used   = CW'(cnt_q) - CW'(pop) + in_flight;
    credit = (used < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;

    pipe_d[0] = rd_q;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start && (length != '0)) begin
          base_d  = base_addr;
          len_d   = length;
          loop_d  = loop_en;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_FLUSH;
        end else if (credit) begin
          rd_d   = 1'b1;
          addr_d = base_q + idx_q[ADDR_W-1:0];
          if (idx_q == len_q - (ADDR_W+1)'(1)) begin
            idx_d = '0;
            if (!loop_q) begin
              state_d = S_DRAIN;
            end
          end else begin
            idx_d = idx_q + (ADDR_W+1)'(1);
          end
        end
      end
      S_DRAIN: begin
        if (stop) begin
          state_d = S_FLUSH;
        end else if ((in_flight == '0) && (cnt_q == '0)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (in_flight == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= avm_readdata;
    end
  end

endmodule

// File: tb/tb_adc_pwm_table_reader.sv
// Directed bench for adc_pwm_table_reader: behavioural memory with latency 1,
// negedge monitor logging reads and stream transfers, one task per scenario.
module tb_adc_pwm_table_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        loop_en;
  logic        busy;
  logic        done;
  logic [9:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = 32'h0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  rd_addr[$];
  logic [31:0] out_w[$];
  int unsigned out_t[$];
  int          done_cnt = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  adc_pwm_table_reader #(
    .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .base_addr(base_addr), .length(length), .loop_en(loop_en),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [31:0] memw(input logic [9:0] a);
    return 32'hA000_0000 | {22'd0, a};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read) avm_readdata <= memw(avm_address);
  end

  always @(negedge clk) begin
    if (avm_read) rd_addr.push_back(avm_address);
    if (out_valid && out_ready) begin
      out_w.push_back(out_data);
      out_t.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_addr.delete();
    out_w.delete();
    out_t.delete();
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] l, input logic lp);
    tick(1);
    base_addr = b; length = l; loop_en = lp; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%b required 0", name, busy);
    end
    tick(2);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done, avm_read, avm_chipselect, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/done/rd/cs/valid=%b required 00000",
               {busy, done, avm_read, avm_chipselect, out_valid});
    end
    n_cmp++;
    if (avm_address !== 10'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h required 000", avm_address);
    end
    n_cmp++;
    if (out_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h required 00000000", out_data);
    end
    n_cmp++;
    if (avm_byteenable !== 4'hF) begin
      n_bad++; $display("FAIL reset_be: got %h required F", avm_byteenable);
    end
  endtask

  // Test 1: base 0x010, length 4, single pass, ready held high.
  task automatic test_single_pass(input string tag);
    logic [9:0]  ga;
    logic [31:0] gw;
    int unsigned t0;
    clear_logs();
    out_ready = 1'b1;
    do_start(10'h010, 11'd4, 1'b0);
    t0 = cyc;
    wait_idle(50, tag);
    n_cmp++;
    if (rd_addr.size() != 4) begin
      n_bad++; $display("FAIL %s_nreads: got %0d required 4", tag, rd_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      ga = (i < rd_addr.size()) ? rd_addr[i] : 10'h3FF;
      n_cmp++;
      if (ga !== 10'h010 + 10'(i)) begin
        n_bad++; $display("FAIL %s_addr%0d: got %h required %h", tag, i, ga, 10'h010 + 10'(i));
      end
    end
    n_cmp++;
    if (out_w.size() != 4) begin
      n_bad++; $display("FAIL %s_nwords: got %0d required 4", tag, out_w.size());
    end
    for (int i = 0; i < 4; i++) begin
      gw = (i < out_w.size()) ? out_w[i] : 32'h0;
      n_cmp++;
      if (gw !== 32'hA000_0010 + 32'(i)) begin
        n_bad++; $display("FAIL %s_word%0d: got %h required %h", tag, i, gw, 32'hA000_0010 + 32'(i));
      end
    end
    if (out_t.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (out_t[i] != out_t[0] + i) begin
          n_bad++; $display("FAIL %s_gap%0d: cycle %0d required %0d", tag, i, out_t[i], out_t[0] + i);
        end
      end
      n_cmp++;
      if (out_t[0] < t0 + 2) begin
        n_bad++; $display("FAIL %s_first_latency: cycle %0d required >= %0d", tag, out_t[0], t0 + 2);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL %s_done: got %0d pulses required 1", tag, done_cnt);
    end
  endtask

  // Test 2: length 8 with out_ready low; only FIFO_DEPTH reads until released.
  task automatic test_backpressure();
    logic [9:0]  ga;
    logic [31:0] gw;
    clear_logs();
    out_ready = 1'b0;
    do_start(10'h100, 11'd8, 1'b0);
    tick(20);
    n_cmp++;
    if (rd_addr.size() != 4) begin
      n_bad++; $display("FAIL bp_stalled_reads: got %0d required 4", rd_addr.size());
    end
    n_cmp++;
    if (avm_read !== 1'b0) begin
      n_bad++; $display("FAIL bp_read_low: got %b required 0", avm_read);
    end
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 32'hA000_0100}) begin
      n_bad++; $display("FAIL bp_head: valid=%b data=%h required 1 A0000100", out_valid, out_data);
    end
    out_ready = 1'b1;
    wait_idle(60, "bp");
    n_cmp++;
    if (rd_addr.size() != 8 || out_w.size() != 8) begin
      n_bad++; $display("FAIL bp_counts: reads=%0d words=%0d required 8 8", rd_addr.size(), out_w.size());
    end
    for (int i = 0; i < 8; i++) begin
      ga = (i < rd_addr.size()) ? rd_addr[i] : 10'h3FF;
      gw = (i < out_w.size()) ? out_w[i] : 32'h0;
      n_cmp++;
      if (ga !== 10'h100 + 10'(i) || gw !== 32'hA000_0100 + 32'(i)) begin
        n_bad++; $display("FAIL bp_item%0d: addr=%h word=%h required %h %h",
                          i, ga, gw, 10'h100 + 10'(i), 32'hA000_0100 + 32'(i));
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  // Test 3: address wraps past the top of the 1024-word space.
  task automatic test_wrap();
    logic [9:0]  exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [31:0] exp_w [4] = '{32'hA000_03FE, 32'hA000_03FF, 32'hA000_0000, 32'hA000_0001};
    logic [9:0]  ga;
    logic [31:0] gw;
    clear_logs();
    out_ready = 1'b1;
    do_start(10'h3FE, 11'd4, 1'b0);
    wait_idle(50, "wrap");
    n_cmp++;
    if (rd_addr.size() != 4 || out_w.size() != 4) begin
      n_bad++; $display("FAIL wrap_counts: reads=%0d words=%0d required 4 4", rd_addr.size(), out_w.size());
    end
    for (int i = 0; i < 4; i++) begin
      ga = (i < rd_addr.size()) ? rd_addr[i] : 10'h2AA;
      gw = (i < out_w.size()) ? out_w[i] : 32'h0;
      n_cmp++;
      if (ga !== exp_a[i] || gw !== exp_w[i]) begin
        n_bad++; $display("FAIL wrap_item%0d: addr=%h word=%h required %h %h", i, ga, gw, exp_a[i], exp_w[i]);
      end
    end
  endtask

  // Test 4: looping 3-word table, then stop.
  task automatic test_loop_stop();
    logic [31:0] exp_w [3] = '{32'hA000_0020, 32'hA000_0021, 32'hA000_0022};
    int n = 0;
    int n_at_stop;
    clear_logs();
    out_ready = 1'b1;
    do_start(10'h020, 11'd3, 1'b1);
    while (out_w.size() < 9 && n < 60) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (out_w.size() < 9) begin
      n_bad++; $display("FAIL loop_timeout: words=%0d required >= 9", out_w.size());
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    n_at_stop = out_w.size();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL loop_stop_valid: got %b required 0", out_valid);
    end
    for (int i = 1; i < 9 && i < out_t.size(); i++) begin
      n_cmp++;
      if (out_t[i] != out_t[0] + i) begin
        n_bad++; $display("FAIL loop_gap%0d: cycle %0d required %0d", i, out_t[i], out_t[0] + i);
      end
    end
    for (int i = 0; i < out_w.size(); i++) begin
      n_cmp++;
      if (out_w[i] !== exp_w[i % 3]) begin
        n_bad++; $display("FAIL loop_word%0d: got %h required %h", i, out_w[i], exp_w[i % 3]);
      end
    end
    tick(10);
    n_cmp++;
    if (out_w.size() != n_at_stop) begin
      n_bad++; $display("FAIL loop_after_stop: words=%0d required %0d", out_w.size(), n_at_stop);
    end
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      n_bad++; $display("FAIL loop_end: busy=%b done_pulses=%0d required 0 0", busy, done_cnt);
    end
  endtask

  // Test 5: asynchronous reset in the middle of a run.
  task automatic test_async_reset();
    clear_logs();
    out_ready = 1'b1;
    do_start(10'h080, 11'd16, 1'b0);
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, avm_read, avm_chipselect, out_valid} !== 5'b0 ||
        avm_address !== 10'h0 || out_data !== 32'h0) begin
      n_bad++; $display("FAIL areset_outputs: ctrl=%b addr=%h data=%h required 00000 000 00000000",
                        {busy, done, avm_read, avm_chipselect, out_valid}, avm_address, out_data);
    end
    tick(2);
    #3;
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL areset_quiet: done_pulses=%0d busy=%b required 0 0", done_cnt, busy);
    end
    test_single_pass("after_reset");
  endtask

  // Test 6: zero-length start and start during a run are ignored.
  task automatic test_start_ignored();
    logic [9:0] ga;
    clear_logs();
    out_ready = 1'b1;
    do_start(10'h050, 11'd0, 1'b0);
    tick(5);
    n_cmp++;
    if (busy !== 1'b0 || rd_addr.size() != 0) begin
      n_bad++; $display("FAIL zero_len: busy=%b reads=%0d required 0 0", busy, rd_addr.size());
    end
    do_start(10'h040, 11'd4, 1'b0);
    tick(1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_run: got %b required 1", busy);
    end
    do_start(10'h200, 11'd2, 1'b0);
    wait_idle(50, "restart");
    n_cmp++;
    if (rd_addr.size() != 4 || out_w.size() != 4 || done_cnt != 1) begin
      n_bad++; $display("FAIL restart_counts: reads=%0d words=%0d done=%0d required 4 4 1",
                        rd_addr.size(), out_w.size(), done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      ga = (i < rd_addr.size()) ? rd_addr[i] : 10'h3FF;
      n_cmp++;
      if (ga !== 10'h040 + 10'(i)) begin
        n_bad++; $display("FAIL restart_addr%0d: got %h required %h", i, ga, 10'h040 + 10'(i));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    base_addr = '0; length = '0; loop_en = 1'b0; out_ready = 1'b0;
    test_reset();
    #21;
    reset = 1'b0;
    tick(2);
    test_single_pass("basic");
    test_backpressure();
    test_wrap();
    test_loop_stop();
    test_async_reset();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
